// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-4 one-bit demultiplexer.
// Select encodings name the destination output directly.
package demux_pkg;

   localparam int SEL_W = 2;
   localparam int N_OUT = 4;

   localparam logic [SEL_W-1:0] SEL_O0 = 2'b00;
   localparam logic [SEL_W-1:0] SEL_O1 = 2'b01;
   localparam logic [SEL_W-1:0] SEL_O2 = 2'b10;
   localparam logic [SEL_W-1:0] SEL_O3 = 2'b11;

endpackage

// File: rtl/dec_2to4.sv
// Combinational 2-to-4 decoder with enable; y is one-hot when en=1, else zero.
// An unknown select falls into the default branch so y can never have two bits high.
module dec_2to4
   import demux_pkg::*;
(
   input  logic [SEL_W-1:0] sel,
   input  logic             en,
   output logic [N_OUT-1:0] y
);

   always_comb begin
      y = '0;
      case (sel)
         SEL_O0:  y = {3'b000, en};
         SEL_O1:  y = {2'b00, en, 1'b0};
         SEL_O2:  y = {1'b0, en, 2'b00};
         SEL_O3:  y = {en, 3'b000};
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/demux_1to4_1bit_d.sv
// One-bit 1-to-4 demultiplexer with registered outputs (one cycle latency).
// The output register is the only state; it clears synchronously on rst.
module demux_1to4_1bit_d
   import demux_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i,
   input  logic [SEL_W-1:0] sel,
   output logic             o0,
   output logic             o1,
   output logic             o2,
   output logic             o3
);

   logic [N_OUT-1:0] dec_y;
   logic [N_OUT-1:0] out_q;

   dec_2to4 u_dec (
      .sel (sel),
      .en  (i),
      .y   (dec_y)
   );

   // Registering the decode keeps outputs glitch-free and cuts any input-to-output path.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q <= '0;
      end else begin
         out_q <= dec_y;
      end
   end

   assign o0 = out_q[0];
   assign o1 = out_q[1];
   assign o2 = out_q[2];
   assign o3 = out_q[3];

endmodule

// File: tb/tb_demux_1to4_1bit_d.sv
// Directed and randomised checks of the registered 1-to-4 demultiplexer.
module tb_demux_1to4_1bit_d;

   logic       clk;
   logic       rst;
   logic       i;
   logic [1:0] sel;
   logic       o0, o1, o2, o3;

   int checks;
   int errors;
   logic chk_en;

   logic [3:0] dec_tab [4];

   demux_1to4_1bit_d dut (
      .clk (clk),
      .rst (rst),
      .i   (i),
      .sel (sel),
      .o0  (o0),
      .o1  (o1),
      .o2  (o2),
      .o3  (o3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assert property (@(posedge clk) !chk_en || $onehot0({o3, o2, o1, o0}))
      else $error("FAIL onehot0: outputs=%b", {o3, o2, o1, o0});

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic d, input logic [1:0] s);
      rst = r;
      i   = d;
      sel = s;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b1, 2'b10);
      tick();
      checks++;
      if ({o3, o2, o1, o0} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_first: got %b expected 0000", {o3, o2, o1, o0});
      end
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++;
         if ({o3, o2, o1, o0} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold[%0d]: got %b expected 0000", k, {o3, o2, o1, o0});
         end
      end
      chk_en = 1'b1;
   endtask

   task automatic test_routing_sweep();
      for (int s = 0; s < 4; s++) begin
         drive(1'b0, 1'b1, 2'(s));
         for (int e = 0; e < 3; e++) begin
            tick();
            checks++;
            if ({o3, o2, o1, o0} !== dec_tab[s]) begin
               errors++;
               $display("FAIL routing sel=%0d edge=%0d: got %b expected %b",
                        s, e, {o3, o2, o1, o0}, dec_tab[s]);
            end
         end
      end
   endtask

   task automatic test_zero_data();
      for (int s = 0; s < 4; s++) begin
         drive(1'b0, 1'b0, 2'(s));
         tick();
         checks++;
         if ({o3, o2, o1, o0} !== 4'b0000) begin
            errors++;
            $display("FAIL zero_data sel=%0d: got %b expected 0000", s, {o3, o2, o1, o0});
         end
      end
   endtask

   // Sel changes every edge; right after the change the outputs must still show
   // the previous decode, and after the edge the new one.
   task automatic test_latency_onehot();
      logic [1:0] seq [8];
      logic [3:0] prev;
      seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd1, 2'd3};
      drive(1'b0, 1'b1, 2'd3);
      tick();
      prev = 4'b1000;
      for (int k = 0; k < 8; k++) begin
         drive(1'b0, 1'b1, seq[k]);
         #1;
         checks++;
         if ({o3, o2, o1, o0} !== prev) begin
            errors++;
            $display("FAIL latency_hold step=%0d: got %b expected %b", k, {o3, o2, o1, o0}, prev);
         end
         tick();
         checks++;
         if ({o3, o2, o1, o0} !== dec_tab[seq[k]]) begin
            errors++;
            $display("FAIL latency_update step=%0d: got %b expected %b",
                     k, {o3, o2, o1, o0}, dec_tab[seq[k]]);
         end
         prev = dec_tab[seq[k]];
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b0, 1'b1, 2'b01);
      tick();
      checks++;
      if ({o3, o2, o1, o0} !== 4'b0010) begin
         errors++;
         $display("FAIL reset_mid_pre: got %b expected 0010", {o3, o2, o1, o0});
      end
      drive(1'b1, 1'b1, 2'b01);
      tick();
      checks++;
      if ({o3, o2, o1, o0} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_mid_clear: got %b expected 0000", {o3, o2, o1, o0});
      end
      drive(1'b0, 1'b1, 2'b01);
      tick();
      checks++;
      if ({o3, o2, o1, o0} !== 4'b0010) begin
         errors++;
         $display("FAIL reset_mid_release: got %b expected 0010", {o3, o2, o1, o0});
      end
   endtask

   task automatic test_random();
      logic       r, d;
      logic [1:0] s;
      logic [3:0] exp;
      for (int k = 0; k < 1000; k++) begin
         r = ($urandom_range(0, 99) < 5);
         d = 1'($urandom_range(0, 1));
         s = 2'($urandom_range(0, 3));
         drive(r, d, s);
         exp = (r || !d) ? 4'b0000 : dec_tab[s];
         tick();
         checks++;
         if ({o3, o2, o1, o0} !== exp) begin
            errors++;
            $display("FAIL random cyc=%0d rst=%b i=%b sel=%0d: got %b expected %b",
                     k, r, d, s, {o3, o2, o1, o0}, exp);
         end
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      chk_en  = 1'b0;
      dec_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      drive(1'b1, 1'b0, 2'b00);

      test_reset();
      test_routing_sweep();
      test_zero_data();
      test_latency_onehot();
      test_reset_mid();
      test_random();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
